ysyx_22040750_icachectrl_nway: RTL and testbench
================================================

Name: ysyx_22040750_icachectrl_nway

Overview:
Parametrised N-way set-associative instruction cache controller for the fetch stage. It sits between the IFU PC request port, the per-way data SRAM macros, and the AXI read channel to memory. It generalises the 2-way controller in three ways: configurable way count, block size and bus width; per-set round-robin replacement; and a fence.i flush that invalidates every line.

Parameters:
WAYS, 2, associativity; power of two, 1..8
BLOCK_SIZE, 32, line size in bytes
CACHE_SIZE, 4096, total capacity in bytes
BUS_W, 64, AXI read data width in bits
BEATS, BLOCK_SIZE*8/BUS_W, derived; burst length; O_mem_arlen = BEATS-1
SETS, CACHE_SIZE/BLOCK_SIZE/WAYS, derived
OFFT_LEN/INDEX_LEN/TAG_LEN, clog2(BLOCK_SIZE)/clog2(SETS)/32-OFFT_LEN-INDEX_LEN, derived

Ports:
I_clk  in  1  single clock
I_rst  in  1  synchronous active-high reset
I_cpu_addr  in  32  fetch PC, sampled on handshake
I_cpu_rd_req  in  1  fetch request
O_cpu_rd_ready  out  1  controller can accept a request
O_cpu_inst  out  32  returned instruction
O_cpu_rvalid  out  1  O_cpu_inst valid, one-cycle pulse
I_flush  in  1  fence.i invalidate request
O_flush_done  out  1  one-cycle pulse when invalidation completes
I_way_rdata  in  WAYS*BLOCK_SIZE*8  per-way SRAM read data; way k at slice k
O_sram_addr  out  INDEX_LEN  SRAM set index
O_sram_cen  out  WAYS  per-way chip enable, active low
O_sram_wen  out  WAYS  per-way write enable, active low
O_sram_wdata  out  BLOCK_SIZE*8  full-line write data
I_mem_arready  in  1  AXI AR ready
O_mem_arvalid  out  1  AXI AR valid
O_mem_araddr  out  32  line-aligned address
O_mem_arlen  out  8  constant BEATS-1
O_mem_arsize  out  3  constant clog2(BUS_W/8)
I_mem_rdata  in  BUS_W  AXI R data
I_mem_rvalid  in  1  AXI R valid
I_mem_rlast  in  1  AXI R last
O_mem_rready  out  1  constant 1

Behaviour:
- States: IDLE, HIT, MISS, RELOAD, ALLOC, FLUSH (one-hot).
- Reset values:
  - state IDLE; all valid bits 0; round-robin pointers 0; tags 0.
  - Outputs: arvalid 0, rvalid 0, flush_done 0, cen all 1, wen all 1.
- Ready and handshake:
  - O_cpu_rd_ready = (IDLE or HIT) and not I_flush; I_flush has priority over a request in the same cycle.
  - Handshake = I_cpu_rd_req and O_cpu_rd_ready. On handshake, the address is latched into the miss-address register.
- Lookup is combinational on I_cpu_addr: tag compare plus valid for every way of the set.
  - Hit: assert cen for the hit way only; O_sram_addr = index; go to HIT.
  - HIT cycle: rvalid=1; inst = word selected from the registered hit-way slice at latched offset[OFFT_LEN-1:2].
  - Hit latency is 1 cycle. A new request may be accepted in HIT, giving back-to-back hits at one per cycle.
  - Multiple ways hitting is illegal; lowest index wins.
- Miss: go to MISS.
  - arvalid=1 and araddr = latched address with offset zeroed; both held stable until arready, then go to RELOAD.
- RELOAD:
  - Each rvalid beat shifts into the line buffer from the MSB side, so beat 0 ends at bits [BUS_W-1:0].
  - rlast moves to ALLOC regardless of the beat count. A beat-count mismatch is a protocol error; there is no recovery.
- ALLOC (one cycle):
  - Victim is the lowest-index invalid way; if all ways are valid, the set's round-robin pointer.
  - Pointer increments (mod WAYS) only when an all-valid set is replaced.
  - Victim way gets cen=0, wen=0, wdata = line buffer, O_sram_addr = miss index.
  - Tag and valid for the victim are written on this edge.
  - rvalid=1; inst taken from the line buffer at the latched offset. Then go to IDLE.
- FLUSH:
  - I_flush seen in IDLE/HIT: go to FLUSH, clear all valid bits on that edge; O_flush_done=1 in FLUSH; next state IDLE.
  - I_flush during MISS/RELOAD/ALLOC is latched as pending and serviced after ALLOC instead of going to IDLE. The just-filled line is therefore invalidated.
  - Pointers are not cleared by flush.
- Reset mid-operation (any state): next cycle is IDLE.
  - arvalid drops immediately.
  - Remaining R beats of an abandoned burst are consumed (rready=1) and ignored.
  - Valid bits are cleared.
- Simultaneous events: a request with I_flush present is not accepted; an rvalid beat in MISS (before arready) is ignored.

Optional Feature:
ICACHE_PERF_EN
- Defined: adds outputs O_perf_hit[31:0] and O_perf_miss[31:0].
  - Hit counter increments per hit handshake; miss counter increments per miss handshake.
  - Both saturate at 0xFFFFFFFF and are cleared by I_rst only (not by flush).
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Cold miss, WAYS=2, fetch 0x80000008, arready after 2 cycles, 4 beats (beat i = 64'h1111_1111_0000_0000*i + i) -> araddr 0x80000000, arlen 3, arsize 3; ALLOC writes way0; inst = beat1[31:0] = 32'h00000001; rvalid one cycle.
- Hit: after the fill, fetch 0x8000000C -> rvalid next cycle, no arvalid, inst = beat1[63:32]; back-to-back fetches of 0x80000000 and 0x80000004 -> two consecutive rvalid cycles.
- Replacement: fill 0x80000000, 0x80000800, 0x80001000 (same set, WAYS=2) -> ways 0, 1, 0 written. Refetch 0x80000800 hits; 0x80000000 misses and is written into way1.
- Flush: after a fill, pulse I_flush with I_cpu_rd_req high -> ready 0 that cycle, flush_done next cycle; refetch of 0x80000000 misses. I_flush during RELOAD -> flush_done the cycle after ALLOC.
- Backpressure/reset: arready low 5 cycles -> arvalid and araddr stable; I_rst asserted mid-RELOAD -> IDLE, rvalid never pulses, the next fetch of the same address misses.
- ICACHE_PERF_EN: 3 misses + 5 hits -> O_perf_miss=3, O_perf_hit=5; the counts survive a flush.

Source files
------------

// File: rtl/ysyx_22040750_icachectrl_nway.sv
// N-way set-associative fetch cache controller: per-set round-robin replacement, fence.i flush.
// Define ICACHE_PERF_EN to add saturating hit/miss counters on O_perf_hit / O_perf_miss.
module ysyx_22040750_icachectrl_nway #(
  parameter int WAYS       = 2,
  parameter int BLOCK_SIZE = 32,
  parameter int CACHE_SIZE = 4096,
  parameter int BUS_W      = 64,
  localparam int BEATS     = BLOCK_SIZE * 8 / BUS_W,
  localparam int SETS      = CACHE_SIZE / BLOCK_SIZE / WAYS,
  localparam int OFFT_LEN  = $clog2(BLOCK_SIZE),
  localparam int INDEX_LEN = $clog2(SETS),
  localparam int TAG_LEN   = 32 - OFFT_LEN - INDEX_LEN,
  localparam int LINE      = BLOCK_SIZE * 8
) (
`ifdef ICACHE_PERF_EN
  output logic [31:0]             O_perf_hit,
  output logic [31:0]             O_perf_miss,
`endif
  input  logic                    I_clk,
  input  logic                    I_rst,
  input  logic [31:0]             I_cpu_addr,
  input  logic                    I_cpu_rd_req,
  output logic                    O_cpu_rd_ready,
  output logic [31:0]             O_cpu_inst,
  output logic                    O_cpu_rvalid,
  input  logic                    I_flush,
  output logic                    O_flush_done,
  input  logic [WAYS*LINE-1:0]    I_way_rdata,
  output logic [INDEX_LEN-1:0]    O_sram_addr,
  output logic [WAYS-1:0]         O_sram_cen,
  output logic [WAYS-1:0]         O_sram_wen,
  output logic [LINE-1:0]         O_sram_wdata,
  input  logic                    I_mem_arready,
  output logic                    O_mem_arvalid,
  output logic [31:0]             O_mem_araddr,
  output logic [7:0]              O_mem_arlen,
  output logic [2:0]              O_mem_arsize,
  input  logic [BUS_W-1:0]        I_mem_rdata,
  input  logic                    I_mem_rvalid,
  input  logic                    I_mem_rlast,
  output logic                    O_mem_rready
);
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int WSEL_W = OFFT_LEN - 2;

  // IDLE | wait for fetch   HIT | return SRAM word   MISS | AR issue
  // RELOAD | collect beats  ALLOC | write victim      FLUSH | invalidate done
  typedef enum logic [5:0] {
    S_IDLE = 6'b000001, S_HIT = 6'b000010, S_MISS = 6'b000100,
    S_RELOAD = 6'b001000, S_ALLOC = 6'b010000, S_FLUSH = 6'b100000
  } state_t;

  state_t                state, state_n;
  logic [TAG_LEN-1:0]    tag_r [WAYS][SETS];
  logic [SETS-1:0]       valid_r [WAYS];
  logic [WAY_W-1:0]      rr_r [SETS];
  logic [31:0]           addr_r;
  logic [LINE-1:0]       line_r, line_n, hit_line;
  logic [WAY_W-1:0]      hit_way_r, hit_way, victim;
  logic                  hit, all_valid, flush_pend_r, hs;
  logic [TAG_LEN-1:0]    req_tag, miss_tag;
  logic [INDEX_LEN-1:0]  req_idx, miss_idx;
  logic [WSEL_W-1:0]     wsel;
  logic                  unused_addr_bits;

  assign req_tag          = I_cpu_addr[31 -: TAG_LEN];
  assign req_idx          = I_cpu_addr[OFFT_LEN +: INDEX_LEN];
  assign miss_tag         = addr_r[31 -: TAG_LEN];
  assign miss_idx         = addr_r[OFFT_LEN +: INDEX_LEN];
  assign wsel             = addr_r[OFFT_LEN-1:2];
  assign unused_addr_bits = ^addr_r[1:0];

  assign O_cpu_rd_ready = ((state == S_IDLE) || (state == S_HIT)) && !I_flush;
  assign hs             = I_cpu_rd_req && O_cpu_rd_ready;
  assign O_mem_araddr   = {addr_r[31:OFFT_LEN], {OFFT_LEN{1'b0}}};
  assign O_mem_arlen    = 8'(BEATS - 1);
  assign O_mem_arsize   = 3'($clog2(BUS_W / 8));
  assign O_mem_rready   = 1'b1;
  assign hit_line       = I_way_rdata[hit_way_r*LINE +: LINE];

  // Descending scan so the lowest matching / invalid way wins.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int k = WAYS - 1; k >= 0; k--) begin
      if (valid_r[k][req_idx] && (tag_r[k][req_idx] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(k);
      end
    end
  end

  always_comb begin
    victim    = rr_r[miss_idx];
    all_valid = 1'b1;
    for (int k = WAYS - 1; k >= 0; k--) begin
      if (!valid_r[k][miss_idx]) begin
        victim    = WAY_W'(k);
        all_valid = 1'b0;
      end
    end
  end

  always_comb begin
    line_n = line_r >> BUS_W;
    line_n[LINE-1 -: BUS_W] = I_mem_rdata;
  end

  always_comb begin
    state_n       = state;
    O_sram_cen    = '1;
    O_sram_wen    = '1;
    O_sram_addr   = miss_idx;
    O_sram_wdata  = line_r;
    O_mem_arvalid = 1'b0;
    O_cpu_rvalid  = 1'b0;
    O_cpu_inst    = '0;
    O_flush_done  = 1'b0;
    case (state)
      S_IDLE, S_HIT: begin
        if (state == S_HIT) begin
          O_cpu_rvalid = 1'b1;
          O_cpu_inst   = hit_line[wsel*32 +: 32];
        end
        if (I_flush) begin
          state_n = S_FLUSH;
        end else if (hs && hit) begin
          O_sram_cen[hit_way] = 1'b0;
          O_sram_addr         = req_idx;
          state_n             = S_HIT;
        end else if (hs) begin
          state_n = S_MISS;
        end else begin
          state_n = S_IDLE;
        end
      end
      S_MISS: begin
        O_mem_arvalid = 1'b1;
        if (I_mem_arready) state_n = S_RELOAD;
      end
      S_RELOAD: if (I_mem_rvalid && I_mem_rlast) state_n = S_ALLOC;
      S_ALLOC: begin
        O_sram_cen[victim] = 1'b0;
        O_sram_wen[victim] = 1'b0;
        O_cpu_rvalid       = 1'b1;
        O_cpu_inst         = line_r[wsel*32 +: 32];
        state_n            = (flush_pend_r || I_flush) ? S_FLUSH : S_IDLE;
      end
      S_FLUSH: begin
        O_flush_done = 1'b1;
        state_n      = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state        <= S_IDLE;
      addr_r       <= '0;
      line_r       <= '0;
      hit_way_r    <= '0;
      flush_pend_r <= 1'b0;
      for (int k = 0; k < WAYS; k++) begin
        valid_r[k] <= '0;
        for (int s = 0; s < SETS; s++) tag_r[k][s] <= '0;
      end
      for (int s = 0; s < SETS; s++) rr_r[s] <= '0;
    end else begin
      state <= state_n;
      if (hs) addr_r <= I_cpu_addr;
      if (hs && hit) hit_way_r <= hit_way;
      if ((state == S_RELOAD) && I_mem_rvalid) line_r <= line_n;
      if (I_flush && ((state == S_MISS) || (state == S_RELOAD))) flush_pend_r <= 1'b1;
      if (state == S_ALLOC) begin
        flush_pend_r             <= 1'b0;
        tag_r[victim][miss_idx]   <= miss_tag;
        valid_r[victim][miss_idx] <= 1'b1;
        if (all_valid)
          rr_r[miss_idx] <= (victim == WAY_W'(WAYS - 1)) ? '0 : victim + 1'b1;
      end
      // A flush entered from ALLOC also drops the line just written.
      if (state_n == S_FLUSH)
        for (int k = 0; k < WAYS; k++) valid_r[k] <= '0;
    end
  end

`ifdef ICACHE_PERF_EN
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      O_perf_hit  <= '0;
      O_perf_miss <= '0;
    end else if (hs) begin
      if (hit && (O_perf_hit != 32'hFFFF_FFFF)) O_perf_hit <= O_perf_hit + 32'd1;
      if (!hit && (O_perf_miss != 32'hFFFF_FFFF)) O_perf_miss <= O_perf_miss + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_22040750_icachectrl_nway.sv
// Bench for the N-way fetch cache controller (default parameters, WAYS=2) against a set/way reference model.
module tb_ysyx_22040750_icachectrl_nway;
  localparam int WAYS = 2, SETS = 64, LINE = 256, BUS_W = 64, BEATS = 4;

  logic              clk = 1'b0;
  logic              rst, cpu_rd_req, flush, mem_arready, mem_rvalid, mem_rlast;
  logic [31:0]       cpu_addr, cpu_inst, mem_araddr;
  logic              cpu_rd_ready, cpu_rvalid, flush_done, mem_arvalid, mem_rready;
  logic [WAYS*LINE-1:0] way_rdata = '0;
  logic [5:0]        sram_addr;
  logic [WAYS-1:0]   sram_cen, sram_wen;
  logic [LINE-1:0]   sram_wdata;
  logic [7:0]        mem_arlen;
  logic [2:0]        mem_arsize;
  logic [BUS_W-1:0]  mem_rdata;
`ifdef ICACHE_PERF_EN
  logic [31:0]       perf_hit, perf_miss;
`endif

  ysyx_22040750_icachectrl_nway dut (
`ifdef ICACHE_PERF_EN
    .O_perf_hit(perf_hit), .O_perf_miss(perf_miss),
`endif
    .I_clk(clk), .I_rst(rst), .I_cpu_addr(cpu_addr), .I_cpu_rd_req(cpu_rd_req),
    .O_cpu_rd_ready(cpu_rd_ready), .O_cpu_inst(cpu_inst), .O_cpu_rvalid(cpu_rvalid),
    .I_flush(flush), .O_flush_done(flush_done), .I_way_rdata(way_rdata),
    .O_sram_addr(sram_addr), .O_sram_cen(sram_cen), .O_sram_wen(sram_wen), .O_sram_wdata(sram_wdata),
    .I_mem_arready(mem_arready), .O_mem_arvalid(mem_arvalid), .O_mem_araddr(mem_araddr),
    .O_mem_arlen(mem_arlen), .O_mem_arsize(mem_arsize), .I_mem_rdata(mem_rdata),
    .I_mem_rvalid(mem_rvalid), .I_mem_rlast(mem_rlast), .O_mem_rready(mem_rready)
  );

  always #5 clk = ~clk;

  // Per-way SRAM macros with a registered read port.
  logic [LINE-1:0] sram [WAYS][SETS];
  always @(posedge clk) begin
    for (int k = 0; k < WAYS; k++) begin
      if (!sram_cen[k]) begin
        if (!sram_wen[k]) sram[k][sram_addr] <= sram_wdata;
        else way_rdata[k*LINE +: LINE] <= sram[k][sram_addr];
      end
    end
  end

  int vectors = 0, miscompares = 0;
  logic [20:0] m_tag [SETS][WAYS];
  bit          m_valid [SETS][WAYS];
  int          m_rr [SETS];
  int          n_hit, n_miss;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] beat(input logic [31:0] la, input int i);
    logic [31:0] off;
    off = la - 32'h8000_0000;
    return 64'h1111_1111_0000_0000 * 64'(i) + 64'(i) + {off, off};
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [63:0] bt;
    bt = beat({a[31:5], 5'b0}, int'(a[4:3]));
    return a[2] ? bt[63:32] : bt[31:0];
  endfunction

  function automatic void model_clear();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
  endfunction

  function automatic void model_reset();
    model_clear();
    for (int s = 0; s < SETS; s++) m_rr[s] = 0;
    n_hit = 0;
    n_miss = 0;
  endfunction

  function automatic int lookup(input int s, input logic [20:0] t);
    for (int w = 0; w < WAYS; w++)
      if (m_valid[s][w] && m_tag[s][w] == t) return w;
    return -1;
  endfunction

  function automatic int pick_victim(input int s);
    for (int w = 0; w < WAYS; w++)
      if (!m_valid[s][w]) return w;
    return m_rr[s];
  endfunction

  task automatic fetch(input logic [31:0] a, input int ar_dly, input int flush_beat, input int rst_beat);
    logic [31:0] la, ei;
    logic [20:0] t;
    logic [1:0]  m;
    logic [LINE-1:0] el;
    int s, w, v;
    bit aborted;
    la = {a[31:5], 5'b0};
    t = a[31:11];
    s = int'(a[10:5]);
    ei = mem_word(a);
    w = lookup(s, t);
    aborted = 1'b0;
    cpu_rd_req = 1'b1;
    cpu_addr = a;
    #1;
    chk("ready", cpu_rd_ready, 1'b1);
    if (w >= 0) begin
      m = '1;
      m[w] = 1'b0;
      chk("hit_cen", sram_cen, m);
      chk("hit_index", sram_addr, 6'(s));
      n_hit++;
      tick();
      cpu_rd_req = 1'b0;
      cpu_addr = $urandom;
      #1;
      chk("hit_rvalid", cpu_rvalid, 1'b1);
      chk("hit_inst", cpu_inst, ei);
      chk("hit_arvalid", mem_arvalid, 1'b0);
      return;
    end
    chk("miss_cen", sram_cen, 2'b11);
    n_miss++;
    tick();
    cpu_rd_req = 1'b0;
    cpu_addr = $urandom;
    #1;
    chk("arvalid", mem_arvalid, 1'b1);
    chk("araddr", mem_araddr, la);
    chk("miss_rvalid", cpu_rvalid, 1'b0);
    for (int i = 0; i < ar_dly; i++) begin
      tick();
      #1;
      chk("arvalid_hold", mem_arvalid, 1'b1);
      chk("araddr_hold", mem_araddr, la);
    end
    mem_arready = 1'b1;
    tick();
    mem_arready = 1'b0;
    for (int b = 0; b < BEATS; b++) begin
      if ($urandom_range(0, 3) == 0) tick();
      mem_rdata = beat(la, b);
      mem_rvalid = 1'b1;
      mem_rlast = (b == BEATS - 1);
      flush = (b == flush_beat);
      rst = (b == rst_beat);
      tick();
      mem_rvalid = 1'b0;
      mem_rlast = 1'b0;
      flush = 1'b0;
      if (rst) begin
        rst = 1'b0;
        aborted = 1'b1;
        model_reset();
      end
      if (aborted) begin
        #1;
        chk("abort_rvalid", cpu_rvalid, 1'b0);
        chk("abort_arvalid", mem_arvalid, 1'b0);
      end
    end
    if (aborted) return;
    #1;
    v = pick_victim(s);
    m = '1;
    m[v] = 1'b0;
    for (int b = 0; b < BEATS; b++) el[b*BUS_W +: BUS_W] = beat(la, b);
    chk("alloc_cen", sram_cen, m);
    chk("alloc_wen", sram_wen, m);
    chk("alloc_index", sram_addr, 6'(s));
    chk("alloc_wdata", sram_wdata, el);
    chk("alloc_rvalid", cpu_rvalid, 1'b1);
    chk("alloc_inst", cpu_inst, ei);
    if (!m_valid[s][v] ? 1'b0 : 1'b1) m_rr[s] = (m_rr[s] + 1) % WAYS;
    m_tag[s][v] = t;
    m_valid[s][v] = 1'b1;
    tick();
    #1;
    chk("rvalid_pulse", cpu_rvalid, 1'b0);
    if (flush_beat >= 0) begin
      chk("flush_done_after_alloc", flush_done, 1'b1);
      model_clear();
      tick();
      #1;
      chk("flush_done_pulse", flush_done, 1'b0);
    end else begin
      chk("no_flush_done", flush_done, 1'b0);
    end
  endtask

  task automatic do_flush(input bit with_req);
    flush = 1'b1;
    cpu_rd_req = with_req;
    cpu_addr = 32'h8000_0000;
    #1;
    chk("flush_ready", cpu_rd_ready, 1'b0);
    chk("flush_cen", sram_cen, 2'b11);
    tick();
    flush = 1'b0;
    cpu_rd_req = 1'b0;
    #1;
    chk("flush_done", flush_done, 1'b1);
    chk("flush_rvalid", cpu_rvalid, 1'b0);
    model_clear();
    tick();
    #1;
    chk("flush_done_pulse", flush_done, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    rst = 1'b1;
    cpu_rd_req = 1'b0;
    cpu_addr = '0;
    flush = 1'b0;
    mem_arready = 1'b0;
    mem_rvalid = 1'b0;
    mem_rlast = 1'b0;
    mem_rdata = '0;
    model_reset();
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_arvalid", mem_arvalid, 1'b0);
    chk("rst_rvalid", cpu_rvalid, 1'b0);
    chk("rst_flush_done", flush_done, 1'b0);
    chk("rst_cen", sram_cen, 2'b11);
    chk("rst_wen", sram_wen, 2'b11);
    chk("rst_ready", cpu_rd_ready, 1'b1);
    chk("arlen", mem_arlen, 8'd3);
    chk("arsize", mem_arsize, 3'd3);
    chk("rready", mem_rready, 1'b1);

    fetch(32'h8000_0008, 2, -1, -1);
    chk("cold_inst_value", mem_word(32'h8000_0008), 32'h0000_0001);
    fetch(32'h8000_000C, 0, -1, -1);
    fetch(32'h8000_0000, 0, -1, -1);
    fetch(32'h8000_0004, 0, -1, -1);
    do_flush(1'b1);
    fetch(32'h8000_0000, 1, -1, -1);
    fetch(32'h8000_0800, 0, -1, -1);
    fetch(32'h8000_1000, 0, -1, -1);
    fetch(32'h8000_0800, 0, -1, -1);
    fetch(32'h8000_0000, 0, -1, -1);
    fetch(32'h8000_0020, 1, 1, -1);
    fetch(32'h8000_0020, 0, -1, -1);
    fetch(32'h8000_0060, 5, -1, -1);
    fetch(32'h8000_0044, 0, -1, 2);
    fetch(32'h8000_0044, 0, -1, -1);
    fetch(32'h8000_0044, 0, -1, -1);

    for (int i = 0; i < 50; i++) begin
      a = 32'h8000_0000 + (32'($urandom_range(0, 3)) << 11) + (32'($urandom_range(0, 1)) << 5)
          + (32'($urandom_range(0, 7)) << 2);
      if ($urandom_range(0, 9) == 0) do_flush(1'($urandom_range(0, 1)));
      else fetch(a, $urandom_range(0, 3), ($urandom_range(0, 7) == 0) ? $urandom_range(0, 3) : -1, -1);
    end

    do_flush(1'b0);
`ifdef ICACHE_PERF_EN
    chk("perf_hit", perf_hit, 32'(n_hit));
    chk("perf_miss", perf_miss, 32'(n_miss));
`endif
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
